// File: rtl/risc_pipe_pkg.sv
// Shared pipeline encodings: buffer occupancy states and write-back source select.
package risc_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam logic [1:0] WB_SEL_ALU   = 2'd0;
    localparam logic [1:0] WB_SEL_MEM   = 2'd1;
    localparam logic [1:0] WB_SEL_CONST = 2'd2;

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with load enable; synchronous reset clears contents.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Hold unless loaded; reset wins over load.
    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mem_wb_pipe_buffer.sv
// Two-entry MEM/WB skid buffer: head (main) entry feeds WB, skid absorbs one
// extra entry so in_ready can be registered instead of following out_ready.
module mem_wb_pipe_buffer
    import risc_pipe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CONST_W = 8,
    parameter int REG_W   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_mem_out,
    input  logic [DATA_W-1:0]  in_alu_out,
    input  logic [CONST_W-1:0] in_lb_const,
    input  logic [REG_W-1:0]   in_fwd_reg,
    input  logic               in_wb_en,
    input  logic [1:0]         in_wb_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_mem_out,
    output logic [DATA_W-1:0]  out_alu_out,
    output logic [CONST_W-1:0] out_lb_const,
    output logic [REG_W-1:0]   out_fwd_reg,
    output logic               out_wb_en,
    output logic [DATA_W-1:0]  out_wb_data,
    output logic               fwd_valid,
    output logic [1:0]         occupancy
);

    localparam int PW = 2*DATA_W + CONST_W + REG_W + 1 + 2;

    buf_state_t    state, state_nxt;
    logic          accept, consume;
    logic          main_ld, skid_ld, main_from_skid;
    logic [PW-1:0] in_pl, main_d, main_q, skid_q;
    logic [1:0]    head_sel;

    assign in_pl   = {in_mem_out, in_alu_out, in_lb_const, in_fwd_reg, in_wb_en, in_wb_sel};
    assign main_d  = main_from_skid ? skid_q : in_pl;
    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    assign {out_mem_out, out_alu_out, out_lb_const, out_fwd_reg, out_wb_en, head_sel} = main_q;

    pipe_payload_reg #(.W(PW)) u_main (
        .clock (clock),
        .reset (reset),
        .en    (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clock (clock),
        .reset (reset),
        .en    (skid_ld),
        .d     (in_pl),
        .q     (skid_q)
    );

    // State register; in_ready is registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != ST_TWO);
        end
    end

    // Next state, payload load controls and occupancy; flush suppresses loads.
    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        out_valid      = 1'b0;
        occupancy      = 2'd0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    main_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
                if (accept && consume) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    skid_ld   = 1'b1;
                end else if (consume) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
                if (consume) begin
                    state_nxt      = ST_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

    // Write-back value selected from the head entry.
    always_comb begin
        out_wb_data = '0;
        case (head_sel)
            WB_SEL_ALU:   out_wb_data = out_alu_out;
            WB_SEL_MEM:   out_wb_data = out_mem_out;
            WB_SEL_CONST: out_wb_data = DATA_W'(out_lb_const);
            default:      out_wb_data = '0;
        endcase
    end

    assign fwd_valid = out_valid && out_wb_en;

endmodule

// File: doc/mem_wb_pipe_buffer.md
MEM_WB_PIPE_BUFFER -- requirements
Module: mem_wb_pipe_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning width of memory-read and ALU result fields.
REQ-002 SHALL have parameter CONST_W, default 8, meaning width of load-byte constant field.
REQ-003 SHALL have parameter REG_W, default 3, meaning width of destination register index.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port in_valid  input  1  MEM stage presents an entry.
REQ-008 SHALL have port in_ready  output  1  buffer accepts an entry this cycle; driven from a register.
REQ-009 SHALL have port in_mem_out  input  DATA_W  memory read data.
REQ-010 SHALL have port in_alu_out  input  DATA_W  ALU result.
REQ-011 SHALL have port in_lb_const  input  CONST_W  load-byte constant.
REQ-012 SHALL have port in_fwd_reg  input  REG_W  destination register.
REQ-013 SHALL have port in_wb_en  input  1  entry writes the register file.
REQ-014 SHALL have port in_wb_sel  input  2  write-back source: 0 ALU, 1 memory, 2 zero-extended constant, 3 reserved.
REQ-015 SHALL have port out_valid  output  1  head entry valid.
REQ-016 SHALL have port out_ready  input  1  WB stage consumes head entry.
REQ-017 SHALL have ports out_mem_out, out_alu_out, out_lb_const, out_fwd_reg, out_wb_en  output  field widths  head-entry fields.
REQ-018 SHALL have port out_wb_data  output  DATA_W  selected write-back value of head entry.
REQ-019 SHALL have port fwd_valid  output  1  head entry valid and out_wb_en set, for hazard unit.
REQ-020 SHALL have port occupancy  output  2  entries held (0..2).

Function
REQ-021 SHALL hold two entries: main (head) and skid; a state machine with states EMPTY, ONE, TWO SHALL track occupancy.
REQ-022 SHALL define accept = in_valid && in_ready and consume = out_valid && out_ready, both evaluated at the same rising edge.
REQ-023 SHALL transition EMPTY->ONE on accept; ONE->EMPTY on consume without accept; ONE->ONE on accept with consume (main loads input); ONE->TWO on accept without consume (skid loads input).
REQ-024 SHALL transition TWO->ONE on consume, moving skid into main; accept is impossible in TWO.
REQ-025 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, registered so it never combinationally depends on out_ready.
REQ-026 SHALL have latency of one cycle: an entry accepted at edge N appears on out_* with out_valid = 1 after edge N when main was empty or consumed at edge N.
REQ-027 SHALL preserve entry order; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-028 SHALL hold out_* fields stable while out_valid = 1 and out_ready = 0.
REQ-029 SHALL compute out_wb_data combinationally from the head: sel 0 out_alu_out, 1 out_mem_out, 2 out_lb_const zero-extended to DATA_W, 3 zero.
REQ-030 SHALL drive fwd_valid = out_valid && out_wb_en.
REQ-031 SHALL on flush go to EMPTY at the next edge with in_ready = 1; a simultaneous accept SHALL be discarded; a simultaneous consume still counts for the WB stage.
REQ-032 SHALL leave payload registers unchanged when their entry is invalidated by consume or flush.
REQ-033 SHALL drive occupancy = 0, 1, 2 for EMPTY, ONE, TWO.

Reset
REQ-034 SHALL on reset zero all payload registers, enter EMPTY, drive out_valid = 0, fwd_valid = 0, occupancy = 0, in_ready = 1 after the edge.
REQ-035 SHALL have reset override flush and all handshakes; reset mid-transfer discards all entries.

Structure
REQ-036 SHALL take state encodings and wb_sel encodings (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_CONST) from shared package risc_pipe_pkg.
REQ-037 SHALL use one sub-module, pipe_payload_reg, a parameterised enable/reset payload register instantiated for main and skid.

Verification
REQ-038 SHALL cover: reset, then in_valid = 1, alu_out = 0x1234, wb_sel = 0, out_ready = 1 -> out_valid = 1 next cycle, out_wb_data = 0x1234.
REQ-039 SHALL cover: out_ready = 0, three back-to-back offers A, B, C -> A, B accepted, in_ready = 0 after B, occupancy = 2; out_ready = 1 -> A, B, C delivered in order.
REQ-040 SHALL cover: lb_const = 0xA5, wb_sel = 2, DATA_W = 16 -> out_wb_data = 0x00A5; wb_sel = 3 -> 0x0000.
REQ-041 SHALL cover: occupancy = 2 and flush with in_valid = 1 -> next cycle out_valid = 0, occupancy = 0, in_ready = 1, offered entry never appears.
REQ-042 SHALL cover: reset asserted in TWO with out_ready = 1 -> all outputs zero, out_valid = 0 next cycle.
REQ-043 SHALL cover: in_wb_en = 0 entry held at head -> out_valid = 1, fwd_valid = 0.
